// File: rtl/elev_disp_pkg.sv
// Shared constants for the elevator scan display: code field layout and segment patterns.
package elev_disp_pkg;

    localparam int unsigned CODE_W     = 5;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned AN_W       = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned LABEL_W    = 4;

    localparam int unsigned CODE_FLOOR_BIT = 4;
    localparam int unsigned REQ_UP_BIT     = 0;
    localparam int unsigned REQ_DN_BIT     = 1;

    localparam logic [SEG_W-1:0] SEG_0     = 8'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 8'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 8'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 8'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 8'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 8'h40;
    localparam logic [SEG_W-1:0] SEG_UP    = 8'h01;
    localparam logic [SEG_W-1:0] SEG_DN    = 8'h08;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
    localparam logic [AN_W-1:0]  AN_OFF    = 8'hFF;

    // Floor labels above 9 have no digit glyph and show a dash.
    function automatic logic [SEG_W-1:0] floor_seg(input logic [LABEL_W-1:0] value);
        logic [SEG_W-1:0] pattern;
        case (value)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/elev_seg_decode.sv
// Combinational decode of one 5-bit display code into a seven-segment pattern.
module elev_seg_decode
    import elev_disp_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              blink_on,
    output logic [SEG_W-1:0]  seg_c
);

    // Labels are steady; request bars only show during the blink-on half.
    always_comb begin
        seg_c = SEG_BLANK;
        if (code[CODE_FLOOR_BIT]) begin
            seg_c = floor_seg(code[LABEL_W-1:0]);
        end else if (blink_on) begin
            if (code[REQ_UP_BIT]) seg_c = seg_c | SEG_UP;
            if (code[REQ_DN_BIT]) seg_c = seg_c | SEG_DN;
        end
    end

endmodule

// File: rtl/elev_scan_display.sv
// Time-multiplexed 8-digit common-anode driver with blank slots between digits.
module elev_scan_display
    import elev_disp_pkg::*;
#(
    parameter int unsigned DWELL      = 2,
    parameter int unsigned BLINK_HALF = 250
)
(
    input  logic              clk_1khz,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] data1,
    input  logic [CODE_W-1:0] data2,
    input  logic [CODE_W-1:0] data3,
    input  logic [CODE_W-1:0] data4,
    input  logic [CODE_W-1:0] data5,
    input  logic [CODE_W-1:0] data6,
    input  logic [CODE_W-1:0] data7,
    input  logic [CODE_W-1:0] data8,
    output logic [AN_W-1:0]   an,
    output logic [SEG_W-1:0]  seg
);

    localparam int unsigned PHASE_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DWELL - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [IDX_W-1:0]   idx;
    logic [PHASE_W-1:0] phase;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic [CODE_W-1:0]  code_sel_c;
    logic [SEG_W-1:0]   seg_dec_c;

    // Scan position and blink timer advance independently every edge.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            phase     <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            if (phase == PHASE_LAST) begin
                phase <= '0;
                idx   <= idx + IDX_W'(1);
            end else begin
                phase <= phase + PHASE_W'(1);
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        code_sel_c = data1;
        case (idx)
            3'd0: code_sel_c = data1;
            3'd1: code_sel_c = data2;
            3'd2: code_sel_c = data3;
            3'd3: code_sel_c = data4;
            3'd4: code_sel_c = data5;
            3'd5: code_sel_c = data6;
            3'd6: code_sel_c = data7;
            3'd7: code_sel_c = data8;
            default: code_sel_c = data1;
        endcase
    end

    elev_seg_decode u_decode (
        .code     (code_sel_c),
        .blink_on (blink_on),
        .seg_c    (seg_dec_c)
    );

    // Phase 0 of every slot is dark so the previous digit never ghosts onto the next.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (phase == '0) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(AN_W'(1) << idx);
            seg <= seg_dec_c;
        end
    end

endmodule

// File: tb/tb_elev_scan_display.sv
// Scoreboard bench: closed-form expected scan output per edge, compared one cycle later.
module tb_elev_scan_display;

    logic       clk_1khz = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [4:0] da [8];
    logic [4:0] db [8];
    logic [7:0] an_a, seg_a, an_b, seg_b;

    int errors = 0;
    int checks = 0;
    int edge_a = 0;
    int edge_b = 0;
    int lit_b [8];

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb [$];

    always #5 clk_1khz = ~clk_1khz;

    elev_scan_display #(.DWELL(2), .BLINK_HALF(5)) dut_a (
        .clk_1khz (clk_1khz), .rst_n (rst_a),
        .data1 (da[0]), .data2 (da[1]), .data3 (da[2]), .data4 (da[3]),
        .data5 (da[4]), .data6 (da[5]), .data7 (da[6]), .data8 (da[7]),
        .an (an_a), .seg (seg_a)
    );

    elev_scan_display #(.DWELL(4), .BLINK_HALF(5)) dut_b (
        .clk_1khz (clk_1khz), .rst_n (rst_b),
        .data1 (db[0]), .data2 (db[1]), .data3 (db[2]), .data4 (db[3]),
        .data5 (db[4]), .data6 (db[5]), .data7 (db[6]), .data8 (db[7]),
        .an (an_b), .seg (seg_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [4:0] code, input bit blink);
        logic [7:0] tbl [16];
        tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        if (code[4]) return tbl[code[3:0]];
        if (!blink) return 8'h00;
        return (code[0] ? 8'h01 : 8'h00) | (code[1] ? 8'h08 : 8'h00);
    endfunction

    // Edge e counts from 1 after reset release; outputs reflect the state before that edge.
    function automatic exp_t ref_out(input int e, input int dwell, input logic [4:0] d [8]);
        exp_t r;
        int   t;
        int   k;
        t = e - 1;
        k = (t / dwell) % 8;
        if ((t % dwell) == 0) begin
            r.an  = 8'hFF;
            r.seg = 8'h00;
        end else begin
            r.an  = ~(8'(1) << k);
            r.seg = ref_seg(d[k], ((t / 5) % 2) == 0);
        end
        return r;
    endfunction

    task automatic step_a(input string tag);
        exp_t e;
        edge_a++;
        sb.push_back(ref_out(edge_a, 2, da));
        @(posedge clk_1khz);
        #1;
        e = sb.pop_front();
        check($sformatf("%s.e%0d.an", tag, edge_a), 32'(an_a), 32'(e.an));
        check($sformatf("%s.e%0d.seg", tag, edge_a), 32'(seg_a), 32'(e.seg));
    endtask

    task automatic step_b();
        exp_t e;
        foreach (db[i]) db[i] = 5'($urandom);
        edge_b++;
        sb.push_back(ref_out(edge_b, 4, db));
        @(posedge clk_1khz);
        #1;
        e = sb.pop_front();
        check($sformatf("b.e%0d.an", edge_b), 32'(an_b), 32'(e.an));
        check($sformatf("b.e%0d.seg", edge_b), 32'(seg_b), 32'(e.seg));
        check($sformatf("b.e%0d.onehot", edge_b),
              32'((an_b == 8'hFF) || $onehot(~an_b)), 32'(1));
        for (int k = 0; k < 8; k++) if (an_b[k] == 1'b0) lit_b[k]++;
    endtask

    task automatic release_a();
        @(negedge clk_1khz);
        rst_a  = 1'b1;
        edge_a = 0;
    endtask

    // Drop reset n edges after a fresh release, 0.3 cycle past the edge.
    task automatic mid_reset(input int n);
        rst_a = 1'b0;
        release_a();
        repeat (n) step_a("pre");
        #2;
        rst_a = 1'b0;
        #1;
        check($sformatf("async%0d.an", n), 32'(an_a), 32'(8'hFF));
        check($sformatf("async%0d.seg", n), 32'(seg_a), 32'(8'h00));
        @(posedge clk_1khz);
        #1;
        check($sformatf("held%0d.an", n), 32'(an_a), 32'(8'hFF));
        release_a();
        repeat (20) step_a("post");
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        foreach (db[i]) db[i] = 5'd0;
        foreach (lit_b[i]) lit_b[i] = 0;

        repeat (3) begin
            foreach (da[i]) da[i] = 5'($urandom);
            @(posedge clk_1khz);
            #1;
            check("rst.an", 32'(an_a), 32'(8'hFF));
            check("rst.seg", 32'(seg_a), 32'(8'h00));
        end

        foreach (da[i]) da[i] = 5'b00000;
        da[7] = 5'b10001;
        da[6] = 5'b00001;
        da[4] = 5'b00011;
        da[0] = 5'b11100;
        release_a();
        repeat (32) step_a("plan");

        repeat (24) begin
            foreach (da[i]) da[i] = 5'($urandom);
            step_a("rand");
        end

        mid_reset(9);
        mid_reset(10);

        @(negedge clk_1khz);
        rst_b  = 1'b1;
        edge_b = 0;
        repeat (992) step_b();
        for (int k = 0; k < 8; k++)
            check($sformatf("b.lit%0d", k), 32'(lit_b[k]), 32'(93));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
